// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light subsystem.
// Contents:
//   sns_state_t  - state encoding of one sensor conditioning channel
//   lc_state_t   - state encoding used by the downstream light controller
//   *_DEF        - default timing constants for the sensor conditioner
//   max_int      - returns the larger of two integers
//   width_for    - returns the bits needed to hold 0..maxval (never below 1)
package tl_pkg;

    typedef enum logic [2:0] {
        SNS_IDLE    = 3'd0,
        SNS_CONFIRM = 3'd1,
        SNS_PRESENT = 3'd2,
        SNS_EXTEND  = 3'd3,
        SNS_FORCED  = 3'd4
    } sns_state_t;

    typedef enum logic [1:0] {
        LC_A_GREEN  = 2'd0,
        LC_A_YELLOW = 2'd1,
        LC_B_GREEN  = 2'd2,
        LC_B_YELLOW = 2'd3
    } lc_state_t;

    localparam int TICK_DIV_DEF = 1000;
    localparam int DEBOUNCE_DEF = 4;
    localparam int HOLD_DEF     = 3;
    localparam int MAXPRES_DEF  = 60;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A zero-valued maximum still needs one bit so that no vector collapses.
    function automatic int width_for(input int maxval);
        int w;
        w = $clog2(maxval + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector conditioning channel.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   tick    - one-cycle timing pulse from the shared prescaler
//   det     - raw asynchronous loop detector input
//   present - registered conditioned presence
//   forced  - registered flag: presence suppressed after MAXPRES ticks
// The detector is synchronised by two flops; the FSM then debounces the rise,
// stretches the fall by HOLD ticks, and drops a detector that stays high for
// MAXPRES ticks so that a stuck loop cannot starve the cross street.
module sensor_channel
    import tl_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int HOLD     = HOLD_DEF,
    parameter int MAXPRES  = MAXPRES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic det,
    output logic present,
    output logic forced
);

    localparam int CW = width_for(max_int(DEBOUNCE, HOLD));
    localparam int PW = width_for(MAXPRES);

    localparam logic [CW-1:0] DEB_C    = CW'(DEBOUNCE);
    localparam logic [CW-1:0] HOLD_C   = CW'(HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [PW-1:0] PMAX_C   = PW'(MAXPRES);
    localparam logic [PW-1:0] PCNT_ONE = PW'(1);
    localparam logic [PW-1:0] PCNT_MAX = {PW{1'b1}};

    logic          sync_meta_r;
    logic          sync_r;
    sns_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] pcnt_r;
    logic          present_r;
    logic          forced_r;

    // Two-flop synchroniser for the asynchronous detector input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= det;
            sync_r      <= sync_meta_r;
        end
    end

    // Channel FSM with counters and outputs registered from the current state.
    // A change of the synchronised input is tested before the tick, so a tick
    // that coincides with a transition is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= SNS_IDLE;
            cnt_r     <= '0;
            pcnt_r    <= '0;
            present_r <= 1'b0;
            forced_r  <= 1'b0;
        end else begin
            present_r <= (state_r == SNS_PRESENT) || (state_r == SNS_EXTEND);
            forced_r  <= (state_r == SNS_FORCED);
            case (state_r)
                SNS_IDLE: begin
                    if (sync_r) begin
                        state_r <= SNS_CONFIRM;
                        cnt_r   <= '0;
                    end
                end
                SNS_CONFIRM: begin
                    if (!sync_r) begin
                        state_r <= SNS_IDLE;
                    end else if (cnt_r >= DEB_C) begin
                        state_r <= SNS_PRESENT;
                        pcnt_r  <= '0;
                    end else if (tick && (cnt_r != CNT_MAX)) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SNS_PRESENT: begin
                    if (!sync_r) begin
                        state_r <= SNS_EXTEND;
                        cnt_r   <= '0;
                    end else if (pcnt_r >= PMAX_C) begin
                        state_r <= SNS_FORCED;
                    end else if (tick && (pcnt_r != PCNT_MAX)) begin
                        pcnt_r <= pcnt_r + PCNT_ONE;
                    end
                end
                SNS_EXTEND: begin
                    // Returning to PRESENT keeps pcnt so a flickering detector
                    // cannot restart the maximum-presence budget.
                    if (sync_r) begin
                        state_r <= SNS_PRESENT;
                    end else if (cnt_r >= HOLD_C) begin
                        state_r <= SNS_IDLE;
                    end else if (tick && (cnt_r != CNT_MAX)) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SNS_FORCED: begin
                    if (!sync_r) begin
                        state_r <= SNS_IDLE;
                    end
                end
                default: begin
                    state_r <= SNS_IDLE;
                end
            endcase
        end
    end

    assign present = present_r;
    assign forced  = forced_r;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the two raw loop detectors feeding the traffic-light controller.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   det_a    - raw asynchronous loop detector, street A
//   det_b    - raw asynchronous loop detector, street B
//   Ta, Tb   - registered conditioned traffic presence for streets A and B
//   force_a  - street A presence suppressed by the maximum-presence limit
//   force_b  - street B presence suppressed by the maximum-presence limit
// A shared prescaler generates the timing tick; each street has its own
// sensor_channel instance.
module traffic_sensor_conditioner
    import tl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int HOLD     = HOLD_DEF,
    parameter int MAXPRES  = MAXPRES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic det_a,
    input  logic det_b,
    output logic Ta,
    output logic Tb,
    output logic force_a,
    output logic force_b
);

    localparam int DW = width_for(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic [DW-1:0] div_r;
    logic          tick_s;

    // Prescaler counting 0..TICK_DIV-1 and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    assign tick_s = (div_r == DIV_LAST);

    sensor_channel #(
        .DEBOUNCE (DEBOUNCE),
        .HOLD     (HOLD),
        .MAXPRES  (MAXPRES)
    ) u_chan_a (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick_s),
        .det     (det_a),
        .present (Ta),
        .forced  (force_a)
    );

    sensor_channel #(
        .DEBOUNCE (DEBOUNCE),
        .HOLD     (HOLD),
        .MAXPRES  (MAXPRES)
    ) u_chan_b (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick_s),
        .det     (det_b),
        .present (Tb),
        .forced  (force_b)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with TICK_DIV=4, DEBOUNCE=3,
// HOLD=2, MAXPRES=10. Inputs change on the falling edge; each table row holds
// its inputs for n rising edges and then compares {Ta,Tb,force_a,force_b} on
// the following falling edge. Edge counts in the comments are numbered from
// the last reset edge (E1 is the first edge with rst low); ticks act on the
// edges E4, E8, E12, ...
module tb_traffic_sensor_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic det_a = 1'b0;
    logic det_b = 1'b0;
    logic Ta, Tb, force_a, force_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic       a;
        logic       b;
        int         n;
        logic [3:0] exp;   // {Ta, Tb, force_a, force_b}
    } vec_t;

    vec_t vq[$];

    traffic_sensor_conditioner #(
        .TICK_DIV (4),
        .DEBOUNCE (3),
        .HOLD     (2),
        .MAXPRES  (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .det_a   (det_a),
        .det_b   (det_b),
        .Ta      (Ta),
        .Tb      (Tb),
        .force_a (force_a),
        .force_b (force_b)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic a, input logic b,
                       input int n, input logic [3:0] e);
        vq.push_back('{r, a, b, n, e});
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got={Ta,Tb,fa,fb}=%b expected=%b", name, got, exp);
        end
    endtask

    initial begin
        int lat;
        int hold_cyc;
        logic tb_leak;

        // reset state
        add(1'b1, 1'b0, 1'b0,  2, 4'b0000);
        // debounce on A: CONFIRM after E3, cnt=3 at E12, PRESENT after E13, Ta at E14
        add(1'b0, 1'b1, 1'b0, 13, 4'b0000);
        add(1'b0, 1'b1, 1'b0,  1, 4'b1000);
        // release: EXTEND after E17, cnt=2 at E24, IDLE after E25, Ta low at E26
        add(1'b0, 1'b0, 1'b0, 11, 4'b1000);
        add(1'b0, 1'b0, 1'b0,  1, 4'b0000);
        // re-pulse during EXTEND, pcnt kept: FORCED after E57, force_a at E58
        add(1'b1, 1'b0, 1'b0,  2, 4'b0000);
        add(1'b0, 1'b1, 1'b0, 14, 4'b1000);
        add(1'b0, 1'b0, 1'b0,  4, 4'b1000);
        add(1'b0, 1'b1, 1'b0,  6, 4'b1000);
        add(1'b0, 1'b1, 1'b0, 33, 4'b1000);
        add(1'b0, 1'b1, 1'b0,  1, 4'b0010);
        add(1'b0, 1'b1, 1'b0, 10, 4'b0010);
        // detector released: IDLE after E71, force_a clears at E72
        add(1'b0, 1'b0, 1'b0,  2, 4'b0010);
        add(1'b0, 1'b0, 1'b0,  1, 4'b0010);
        add(1'b0, 1'b0, 1'b0,  1, 4'b0000);
        // stuck B detector for 80 cycles: FORCED after E53, force_b at E54
        add(1'b1, 1'b0, 1'b0,  2, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 14, 4'b0100);
        add(1'b0, 1'b0, 1'b1, 39, 4'b0100);
        add(1'b0, 1'b0, 1'b1,  1, 4'b0001);
        add(1'b0, 1'b0, 1'b1, 26, 4'b0001);
        add(1'b0, 1'b0, 1'b0,  3, 4'b0001);
        add(1'b0, 1'b0, 1'b0,  1, 4'b0000);
        // 5-cycle glitch rejected, then a fresh rise needs the full debounce
        add(1'b1, 1'b0, 1'b0,  2, 4'b0000);
        add(1'b0, 1'b1, 1'b0,  5, 4'b0000);
        add(1'b0, 1'b0, 1'b0,  3, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 20, 4'b0000);
        add(1'b0, 1'b1, 1'b0, 13, 4'b0000);
        add(1'b0, 1'b1, 1'b0,  1, 4'b1000);
        // both streets, transitions on tick edges E4 and E24 (tick not counted)
        add(1'b1, 1'b0, 1'b0,  2, 4'b0000);
        add(1'b0, 1'b0, 1'b0,  1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 16, 4'b0000);
        add(1'b0, 1'b1, 1'b1,  1, 4'b1100);
        add(1'b0, 1'b1, 1'b1,  3, 4'b1100);
        add(1'b0, 1'b0, 1'b0,  2, 4'b1100);
        add(1'b0, 1'b0, 1'b0, 10, 4'b1100);
        add(1'b0, 1'b0, 1'b0,  1, 4'b0000);
        // one-cycle reset while Ta=1 with det_a held
        add(1'b1, 1'b0, 1'b0,  2, 4'b0000);
        add(1'b0, 1'b1, 1'b0, 14, 4'b1000);
        add(1'b1, 1'b1, 1'b0,  1, 4'b0000);
        add(1'b0, 1'b1, 1'b0, 13, 4'b0000);
        add(1'b0, 1'b1, 1'b0,  1, 4'b1000);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            rst   = vq[i].r;
            det_a = vq[i].a;
            det_b = vq[i].b;
            repeat (vq[i].n) @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d", i), {Ta, Tb, force_a, force_b}, vq[i].exp);
        end

        // Hand sequence: rise latency window and release hold window on A.
        rst = 1'b1; det_a = 1'b0; det_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        det_a = 1'b1;
        lat = 0;
        tb_leak = 1'b0;
        while (!Ta && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (Tb || force_b) tb_leak = 1'b1;
        end
        checks++;
        if (lat < 14 || lat > 18) begin
            errors++;
            $display("FAIL rise_latency got=%0d cycles expected 14..18", lat);
        end
        checks++;
        if (tb_leak) begin
            errors++;
            $display("FAIL tb_isolation got=Tb/force_b active expected=inactive");
        end

        det_a = 1'b0;
        hold_cyc = 0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (Ta) hold_cyc++;
            else break;
        end
        checks++;
        if (hold_cyc < 8 || hold_cyc > 12) begin
            errors++;
            $display("FAIL hold_window got=%0d cycles expected 8..12", hold_cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
